// File: rtl/prbs7_xnor_checker.sv
// Serial PRBS7 (x^7 + x^6 + 1, XNOR feedback) receive checker.
// Self-synchronises from the data, declares lock, then flags and counts bit errors.
module prbs7_xnor_checker #(
   parameter int unsigned LOCK_CNT  = 16,
   parameter int unsigned ERR_LIMIT = 4,
   parameter int unsigned WINDOW    = 64
) (
   input  logic        CP,
   input  logic        RST,
   input  logic        EN,
   input  logic        DIN,
   input  logic        CLR_CNT,
   output logic        LOCK,
   output logic        ERR,
   output logic [15:0] ERR_CNT
);

   localparam int unsigned SW = 7;
   localparam int unsigned MW = 8;
   localparam int unsigned WB = $clog2(WINDOW);
   localparam int unsigned EW = $clog2(WINDOW + 1);
   localparam int unsigned CW = 16;

   typedef enum logic {
      HUNT,
      LOCKED
   } state_t;

   state_t          state_q, state_nxt;
   logic [SW-1:0]   sr_q, sr_nxt;
   logic [MW-1:0]   match_q, match_nxt, match_inc;
   logic [WB-1:0]   wbit_q, wbit_nxt;
   logic [EW-1:0]   werr_q, werr_nxt, werr_base;
   logic [CW-1:0]   cnt_nxt;
   logic            err_nxt;
   logic            lock_nxt;
   logic            cnt_inc;
   logic            pred;
   logic            miss;

   // State and output registers
   always_ff @(posedge CP or posedge RST) begin
      if (RST) begin
         state_q <= HUNT;
         sr_q    <= '0;
         match_q <= '0;
         wbit_q  <= '0;
         werr_q  <= '0;
         LOCK    <= 1'b0;
         ERR     <= 1'b0;
         ERR_CNT <= '0;
      end else begin
         state_q <= state_nxt;
         sr_q    <= sr_nxt;
         match_q <= match_nxt;
         wbit_q  <= wbit_nxt;
         werr_q  <= werr_nxt;
         LOCK    <= lock_nxt;
         ERR     <= err_nxt;
         ERR_CNT <= cnt_nxt;
      end
   end

   // Next-state: hunt loads the line, locked free-runs on the prediction
   always_comb begin
      state_nxt = state_q;
      sr_nxt    = sr_q;
      match_nxt = match_q;
      wbit_nxt  = wbit_q;
      werr_nxt  = werr_q;
      werr_base = werr_q;
      match_inc = match_q + MW'(1);
      err_nxt   = 1'b0;
      cnt_inc   = 1'b0;
      pred      = ~(sr_q[6] ^ sr_q[5]);
      miss      = (DIN != pred);

      if (EN) begin
         case (state_q)
            HUNT: begin
               sr_nxt = {sr_q[SW-2:0], DIN};
               if (!miss && (sr_q != 7'h7F)) begin
                  if (match_inc == MW'(LOCK_CNT)) begin
                     state_nxt = LOCKED;
                     match_nxt = '0;
                  end else begin
                     match_nxt = match_inc;
                  end
               end else begin
                  match_nxt = '0;
               end
            end
            LOCKED: begin
               sr_nxt    = {sr_q[SW-2:0], pred};
               wbit_nxt  = wbit_q + WB'(1);
               // an error on the wrap bit belongs to the new window
               werr_base = (wbit_q == WB'(WINDOW - 1)) ? '0 : werr_q;
               werr_nxt  = werr_base;
               if (miss) begin
                  err_nxt  = 1'b1;
                  cnt_inc  = 1'b1;
                  werr_nxt = werr_base + EW'(1);
                  if (werr_nxt == EW'(ERR_LIMIT)) begin
                     state_nxt = HUNT;
                     wbit_nxt  = '0;
                     werr_nxt  = '0;
                     match_nxt = '0;
                  end
               end
            end
            default: state_nxt = HUNT;
         endcase
      end

      if (CLR_CNT) begin
         cnt_nxt = '0;
      end else if (cnt_inc && (ERR_CNT != 16'hFFFF)) begin
         cnt_nxt = ERR_CNT + CW'(1);
      end else begin
         cnt_nxt = ERR_CNT;
      end

      lock_nxt = (state_nxt == LOCKED);
   end

endmodule

// File: tb/tb_prbs7_xnor_checker.sv
// Bench for prbs7_xnor_checker: sequence-level reference model, directed and random steps.
module tb_prbs7_xnor_checker;

   localparam int LOCK_CNT  = 16;
   localparam int ERR_LIMIT = 4;
   localparam int WINDOW    = 64;

   logic        CP = 1'b0;
   logic        RST = 1'b1;
   logic        EN = 1'b0;
   logic        DIN = 1'b0;
   logic        CLR_CNT = 1'b0;
   logic        LOCK;
   logic        ERR;
   logic [15:0] ERR_CNT;

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;

   prbs7_xnor_checker #(
      .LOCK_CNT (LOCK_CNT),
      .ERR_LIMIT(ERR_LIMIT),
      .WINDOW   (WINDOW)
   ) dut (
      .CP     (CP),
      .RST    (RST),
      .EN     (EN),
      .DIN    (DIN),
      .CLR_CNT(CLR_CNT),
      .LOCK   (LOCK),
      .ERR    (ERR),
      .ERR_CNT(ERR_CNT)
   );

   always #5 CP = ~CP;

   // Reference: the stream as a bit sequence x[n] = xnor(x[n-7], x[n-6])
   bit          gen_q[$];
   bit          m_hist[$];
   bit          m_lock;
   bit          m_err;
   int          m_match;
   int          m_lbits;
   int          m_wid;
   int          m_werr;
   logic [15:0] m_cnt;

   function automatic void gen_reset();
      gen_q.delete();
      for (int i = 0; i < 7; i++) gen_q.push_back(1'b0);
   endfunction

   function automatic bit gen_next();
      bit b;
      b = !(gen_q[0] ^ gen_q[1]);
      gen_q.push_back(b);
      void'(gen_q.pop_front());
      return b;
   endfunction

   function automatic void model_reset();
      m_hist.delete();
      for (int i = 0; i < 7; i++) m_hist.push_back(1'b0);
      m_lock  = 0;
      m_err   = 0;
      m_match = 0;
      m_lbits = 0;
      m_wid   = 0;
      m_werr  = 0;
      m_cnt   = '0;
   endfunction

   function automatic void model_step(input bit en, input bit din, input bit clr);
      bit p;
      bit all_ones;
      bit inc;
      int w;
      m_err = 0;
      inc   = 0;
      if (en) begin
         p = !(m_hist[0] ^ m_hist[1]);
         if (!m_lock) begin
            all_ones = 1;
            foreach (m_hist[i]) if (!m_hist[i]) all_ones = 0;
            if (din == p && !all_ones) m_match++;
            else m_match = 0;
            m_hist.push_back(din);
            if (m_match == LOCK_CNT) begin
               m_lock  = 1;
               m_match = 0;
               m_lbits = 0;
               m_wid   = 0;
               m_werr  = 0;
            end
         end else begin
            m_hist.push_back(p);
            w = (m_lbits + 1) / WINDOW;
            if (w != m_wid) begin
               m_wid  = w;
               m_werr = 0;
            end
            m_lbits++;
            if (din != p) begin
               m_err = 1;
               inc   = 1;
               m_werr++;
               if (m_werr == ERR_LIMIT) begin
                  m_lock  = 0;
                  m_match = 0;
               end
            end
         end
         void'(m_hist.pop_front());
      end
      if (clr) m_cnt = '0;
      else if (inc && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit en, input bit din, input bit clr);
      EN      = en;
      DIN     = din;
      CLR_CNT = clr;
      @(posedge CP);
      model_step(en, din, clr);
      #1;
      check("lock", {15'd0, LOCK}, {15'd0, m_lock});
      check("err", {15'd0, ERR}, {15'd0, m_err});
      check("err_cnt", ERR_CNT, m_cnt);
   endtask

   // Asynchronous reset: outputs must clear before the next clock edge
   task automatic do_reset();
      RST     = 1'b1;
      EN      = 1'b0;
      DIN     = 1'b0;
      CLR_CNT = 1'b0;
      #2;
      check("rst_lock", {15'd0, LOCK}, 16'd0);
      check("rst_err", {15'd0, ERR}, 16'd0);
      check("rst_cnt", ERR_CNT, 16'd0);
      model_reset();
      gen_reset();
      @(posedge CP);
      #1;
      RST = 1'b0;
   endtask

   initial begin
      int  lock_at;
      int  n;
      bit  b;
      bit  seen;
      bit  hit;

      // Reset and clean stream
      do_reset();
      lock_at = -1;
      for (int i = 0; i < 200; i++) begin
         step(1, gen_next(), 0);
         if (LOCK && lock_at < 0) lock_at = i + 1;
      end
      check("clean_lock_bit", 16'(lock_at), 16'd16);
      check("clean_cnt", ERR_CNT, 16'd0);

      // Single error does not corrupt the prediction
      b = gen_next();
      step(1, !b, 0);
      check("single_err", {15'd0, ERR}, 16'd1);
      check("single_lock", {15'd0, LOCK}, 16'd1);
      for (int i = 0; i < 50; i++) step(1, gen_next(), 0);
      check("single_cnt", ERR_CNT, 16'd1);
      check("single_lock_after", {15'd0, LOCK}, 16'd1);

      // Loss of lock: four errors inside one window, then relock
      step(1, gen_next(), 1);
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         if ((m_lbits % WINDOW) <= WINDOW - 10) hit = 1;
         else step(1, gen_next(), 0);
      end
      check("loss_align", {15'd0, hit}, 16'd1);
      for (int i = 0; i < 7; i++) begin
         b = gen_next();
         step(1, (i % 2 == 0) ? !b : b, 0);
      end
      check("loss_lock", {15'd0, LOCK}, 16'd0);
      check("loss_cnt", ERR_CNT, 16'd4);
      n = 0;
      for (int i = 0; i < 40 && !LOCK; i++) begin
         step(1, gen_next(), 0);
         n++;
      end
      check("relock_bits", 16'(n), 16'd16);

      // Window wrap: three errors before the wrap bit, one after
      step(1, gen_next(), 1);
      hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if ((m_lbits % WINDOW) == WINDOW - 4) hit = 1;
         else step(1, gen_next(), 0);
      end
      check("wrap_align", {15'd0, hit}, 16'd1);
      for (int i = 0; i < 6; i++) begin
         b = gen_next();
         step(1, (i == 3 || i == 4) ? b : !b, 0);
      end
      for (int i = 0; i < 20; i++) step(1, gen_next(), 0);
      check("wrap_lock", {15'd0, LOCK}, 16'd1);
      check("wrap_cnt", ERR_CNT, 16'd4);

      // Random errors, EN gaps and clears against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            step(0, 1'($urandom), ($urandom_range(0, 63) == 0));
         end else begin
            b = gen_next();
            step(1, ($urandom_range(0, 31) == 0) ? !b : b, ($urandom_range(0, 63) == 0));
         end
      end

      // CLR_CNT coincident with an error drops that error
      hit = 0;
      for (int i = 0; i < 100 && !hit; i++) begin
         if (LOCK) hit = 1;
         else step(1, gen_next(), 0);
      end
      check("clr_locked", {15'd0, LOCK}, 16'd1);
      b = gen_next();
      step(1, !b, 1);
      check("clr_err", {15'd0, ERR}, 16'd1);
      check("clr_cnt", ERR_CNT, 16'd0);

      // Reset in the middle of lock
      for (int i = 0; i < 10; i++) step(1, gen_next(), 0);
      check("pre_rst_lock", {15'd0, LOCK}, 16'd1);
      do_reset();

      // Stuck-high line never locks
      seen = 0;
      for (int i = 0; i < 300; i++) begin
         step(1, 1'b1, 0);
         if (LOCK) seen = 1;
      end
      check("stuck_no_lock", {15'd0, seen}, 16'd0);

      // Clean stream with random EN gaps still locks without errors
      do_reset();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 2) != 0) step(1, gen_next(), 0);
         else step(0, 1'($urandom), 0);
      end
      check("gap_lock", {15'd0, LOCK}, 16'd1);
      check("gap_cnt", ERR_CNT, 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
